// File: rtl/data_memory_io.sv
// Data memory and memory-mapped I/O on the CPU load/store port: byte-enabled RAM,
// LED/HEX registers, synchronised switches/keys, sticky key edges with irq, cycle counter.
module data_memory_io #(
  parameter string MEM_INIT_FILE       = "",
  parameter int    ADDR_BIT_WIDTH      = 32,
  parameter int    DATA_BIT_WIDTH      = 32,
  parameter int    TRUE_ADDR_BIT_WIDTH = 11,
  parameter int    IO_SEL_BIT          = 29,
  parameter int    N_KEYS              = 4,
  parameter int    N_SW                = 10,
  parameter int    N_LEDR              = 10,
  parameter int    N_LEDG              = 8,
  parameter int    HEX_BITS            = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wrtEn,
  input  logic [3:0]                byteEn,
  input  logic [ADDR_BIT_WIDTH-1:0] addr,
  input  logic [DATA_BIT_WIDTH-1:0] dIn,
  input  logic [N_SW-1:0]           sw,
  input  logic [N_KEYS-1:0]         key,
  output logic [N_LEDR-1:0]         ledr,
  output logic [N_LEDG-1:0]         ledg,
  output logic [HEX_BITS-1:0]       hex,
  output logic                      keyIrq,
  output logic [DATA_BIT_WIDTH-1:0] dOut
);

  localparam int N_WORDS = 1 << TRUE_ADDR_BIT_WIDTH;

  localparam logic [3:0] OFF_KEY     = 4'd0;
  localparam logic [3:0] OFF_SW      = 4'd1;
  localparam logic [3:0] OFF_LEDR    = 4'd2;
  localparam logic [3:0] OFF_LEDG    = 4'd3;
  localparam logic [3:0] OFF_HEX     = 4'd4;
  localparam logic [3:0] OFF_KEYEDGE = 4'd5;
  localparam logic [3:0] OFF_KEYIE   = 4'd6;
  localparam logic [3:0] OFF_CYCLES  = 4'd7;

  logic                           io_sel;
  logic [3:0]                     io_off;
  logic [TRUE_ADDR_BIT_WIDTH-1:0] word_idx;
  logic                           io_wr;

  assign io_sel   = addr[IO_SEL_BIT];
  assign io_off   = addr[5:2];
  assign word_idx = addr[TRUE_ADDR_BIT_WIDTH+1:2];
  assign io_wr    = wrtEn & io_sel;

  // Address bits outside the decode fields are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr;

  (* ram_init_file = MEM_INIT_FILE *)
  logic [DATA_BIT_WIDTH-1:0] mem [N_WORDS];
  logic [DATA_BIT_WIDTH-1:0] ram_q;

  // Read-first synchronous RAM on the falling edge: data is ready before the next rising edge.
  always_ff @(negedge clk) begin
    if (wrtEn && !io_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[word_idx][8*i +: 8] <= dIn[8*i +: 8];
      end
    end
    ram_q <= mem[word_idx];
  end

  logic [N_SW-1:0]   sw_s1, sw_s2;
  logic [N_KEYS-1:0] key_s1, key_s2, key_d;
  logic [N_KEYS-1:0] key_edge, key_edge_next, key_ie, key_clr;
  logic [31:0]       cycles;

  always_comb begin
    key_clr = '0;
    if (io_wr && io_off == OFF_KEYEDGE) key_clr = dIn[N_KEYS-1:0];
    // A new edge overrides a simultaneous write-1-to-clear.
    key_edge_next = (key_edge & ~key_clr) | (key_s2 & ~key_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      key_s1   <= '0;
      key_s2   <= '0;
      key_d    <= '0;
      key_edge <= '0;
      key_ie   <= '0;
      cycles   <= '0;
      ledr     <= '0;
      ledg     <= '0;
      hex      <= '0;
    end else begin
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      key_s1   <= ~key;
      key_s2   <= key_s1;
      key_d    <= key_s2;
      key_edge <= key_edge_next;
      cycles   <= cycles + 32'd1;
      if (io_wr) begin
        case (io_off)
          OFF_LEDR:  ledr   <= dIn[N_LEDR-1:0];
          OFF_LEDG:  ledg   <= dIn[N_LEDG-1:0];
          OFF_HEX:   hex    <= dIn[HEX_BITS-1:0];
          OFF_KEYIE: key_ie <= dIn[N_KEYS-1:0];
          default: ;
        endcase
      end
    end
  end

  assign keyIrq = |(key_edge & key_ie);

  logic [DATA_BIT_WIDTH-1:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    case (io_off)
      OFF_KEY:     io_rdata[N_KEYS-1:0]   = key_s2;
      OFF_SW:      io_rdata[N_SW-1:0]     = sw_s2;
      OFF_LEDR:    io_rdata[N_LEDR-1:0]   = ledr;
      OFF_LEDG:    io_rdata[N_LEDG-1:0]   = ledg;
      OFF_HEX:     io_rdata[HEX_BITS-1:0] = hex;
      OFF_KEYEDGE: io_rdata[N_KEYS-1:0]   = key_edge;
      OFF_KEYIE:   io_rdata[N_KEYS-1:0]   = key_ie;
      OFF_CYCLES:  io_rdata               = cycles;
      default: ;
    endcase
  end

  assign dOut = io_sel ? io_rdata : ram_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Scoreboard bench for data_memory_io: stimulus pushes expected values, a monitor
// process pops and compares them against the selected DUT output mid-cycle.
module tb_data_memory_io;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrtEn;
  logic [3:0]  byteEn;
  logic [31:0] addr;
  logic [31:0] dIn;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [15:0] hex;
  logic        keyIrq;
  logic [31:0] dOut;

  localparam int N_WORDS = 1 << 11;
  localparam logic [31:0] IO_BASE = 32'h2000_0000;

  data_memory_io dut (
    .clk(clk), .reset(reset), .wrtEn(wrtEn), .byteEn(byteEn), .addr(addr), .dIn(dIn),
    .sw(sw), .key(key), .ledr(ledr), .ledg(ledg), .hex(hex), .keyIrq(keyIrq), .dOut(dOut)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  string       nameq[$];
  int          selq[$];
  logic [31:0] expq[$];
  logic        pending = 1'b0;

  // sel: 0 dOut, 1 ledr, 2 ledg, 3 hex, 4 keyIrq
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (pending) begin
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty: got output with no expected value queued");
        end else begin
          string       n;
          int          s;
          logic [31:0] e, act;
          n = nameq.pop_front();
          s = selq.pop_front();
          e = expq.pop_front();
          case (s)
            0: act = dOut;
            1: act = {22'd0, ledr};
            2: act = {24'd0, ledg};
            3: act = {16'd0, hex};
            default: act = {31'd0, keyIrq};
          endcase
          vectors++;
          if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, e);
          end
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a; wrtEn = 1'b0;
    nameq.push_back(n); selq.push_back(sel); expq.push_back(e);
    pending = 1'b1;
    @(posedge clk); #1;
    pending = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; dIn = d; byteEn = be; wrtEn = 1'b1;
    @(posedge clk); #1;
    wrtEn = 1'b0; byteEn = 4'h0;
  endtask

  // Store and load the same word in one cycle.
  task automatic wchk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] e, input string n);
    addr = a; dIn = d; byteEn = be; wrtEn = 1'b1;
    nameq.push_back(n); selq.push_back(0); expq.push_back(e);
    pending = 1'b1;
    @(posedge clk); #1;
    pending = 1'b0; wrtEn = 1'b0; byteEn = 4'h0;
  endtask

  function automatic logic [31:0] ram_a(input int idx);
    logic [31:0] hi;
    hi = $urandom & 32'h0000_FFFF;
    return (32'(idx) << 2) | (hi << 13) | 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] io_a(input int off);
    return IO_BASE | (32'(off) << 2) | ($urandom & 32'h1FFF_FFC3);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [31:0] ram_m [16];

  initial begin
    reset = 1'b1; wrtEn = 1'b0; byteEn = 4'h0; addr = '0; dIn = '0;
    sw = '0; key = 4'hF;
    @(posedge clk); #1;

    chk(1, 32'h0, 32'h0, "rst_ledr");
    chk(2, 32'h0, 32'h0, "rst_ledg");
    chk(3, 32'h0, 32'h0, "rst_hex");
    chk(4, 32'h0, 32'h0, "rst_irq");
    chk(0, io_a(5), 32'h0, "rst_keyedge");
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // RAM byte lanes, wrap, empty byte mask, read-old-on-write
    store(32'h100, 32'hAABB_CCDD, 4'hF);
    store(32'h100, 32'h1122_3344, 4'h5);
    chk(0, 32'h100, 32'hAA22_CC44, "ram_lanes");
    chk(0, 32'h100 + N_WORDS*4, 32'hAA22_CC44, "ram_wrap");
    store(32'h100, 32'hFFFF_FFFF, 4'h0);
    chk(0, 32'h100, 32'hAA22_CC44, "ram_be0");
    store(32'h104, 32'h0BAD_F00D, 4'hF);
    wchk(32'h104, 32'h1234_5678, 4'hF, 32'h0BAD_F00D, "ram_rd_old");
    chk(0, 32'h104, 32'h1234_5678, "ram_rd_new");

    for (int i = 0; i < 16; i++) begin
      ram_m[i] = $urandom;
      store(ram_a(512 + i), ram_m[i], 4'hF);
    end
    for (int i = 0; i < 60; i++) begin
      int idx;
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] d;
        logic [3:0]  be;
        d  = $urandom;
        be = 4'($urandom_range(0, 15));
        store(ram_a(512 + idx), d, be);
        ram_m[idx] = merge(ram_m[idx], d, be);
      end else begin
        chk(0, ram_a(512 + idx), ram_m[idx], "ram_rand");
      end
    end

    // LED/HEX and read-only/unmapped offsets
    store(32'h2000_0008, 32'h0000_03FF, 4'h0);
    chk(1, 32'h0, 32'h3FF, "ledr_out");
    store(32'h2000_0010, 32'h0000_BEEF, 4'h0);
    chk(3, 32'h0, 32'hBEEF, "hex_out");
    chk(0, 32'h2000_0008, 32'h3FF, "ledr_rd");
    chk(0, 32'h2000_0010, 32'hBEEF, "hex_rd");
    store(32'h2000_0004, 32'h0000_03FF, 4'hF);
    chk(0, 32'h2000_0004, 32'h0, "sw_ro");
    store(io_a(9), 32'hFFFF_FFFF, 4'hF);
    chk(0, io_a(9), 32'h0, "unmapped");

    for (int i = 0; i < 12; i++) begin
      int          off;
      logic [31:0] d, m;
      off = $urandom_range(2, 4);
      d   = $urandom;
      m   = (off == 2) ? 32'h3FF : (off == 3) ? 32'hFF : 32'hFFFF;
      store(io_a(off), d, 4'($urandom_range(0, 15)));
      chk(off - 1, 32'h0, d & m, "io_out_rand");
      chk(0, io_a(off), d & m, "io_rd_rand");
    end

    // Switch synchroniser latency
    sw = 10'h155;
    chk(0, io_a(1), 32'h0, "sw_sync0");
    chk(0, io_a(1), 32'h0, "sw_sync1");
    chk(0, io_a(1), 32'h155, "sw_sync2");
    for (int i = 0; i < 6; i++) begin
      logic [9:0] v;
      v  = 10'($urandom_range(0, 1023));
      sw = v;
      idle(); idle();
      chk(0, io_a(1), {22'd0, v}, "sw_rand");
    end

    // Key edge capture and interrupt
    store(io_a(6), 32'h4, 4'h0);
    chk(0, io_a(6), 32'h4, "keyie_rd");
    key = 4'b1011;
    chk(0, io_a(0), 32'h0, "key_sync0");
    chk(0, io_a(0), 32'h0, "key_sync1");
    chk(0, io_a(0), 32'h4, "key_sync2");
    chk(4, 32'h0, 32'h1, "irq_set");
    chk(0, io_a(5), 32'h4, "keyedge_set");
    store(io_a(5), 32'h4, 4'h0);
    chk(0, io_a(5), 32'h0, "keyedge_w1c");
    chk(4, 32'h0, 32'h0, "irq_clr");
    key = 4'b1001;
    idle(); idle();
    chk(0, io_a(5), 32'h0, "keyedge_lat2");
    chk(0, io_a(5), 32'h2, "keyedge_lat3");
    chk(4, 32'h0, 32'h0, "irq_masked");

    // Set wins over a simultaneous clear; a 0 in the W1C data leaves bit 1 alone
    key = 4'b1000;
    idle(); idle();
    store(io_a(5), 32'h1, 4'h0);
    chk(0, io_a(5), 32'h3, "set_beats_clr");
    store(io_a(5), 32'h2, 4'h0);
    chk(0, io_a(5), 32'h1, "w1c_bit1");
    store(io_a(6), 32'h1, 4'h0);
    chk(4, 32'h0, 32'h1, "irq_bit0");

    // Asynchronous reset mid-cycle, then cycle counter
    store(32'h2000_0008, 32'h2AA, 4'h0);
    store(32'h2000_000C, 32'h5A, 4'h0);
    key = 4'hF;
    #1 reset = 1'b1;
    chk(1, 32'h0, 32'h0, "arst_ledr");
    chk(2, 32'h0, 32'h0, "arst_ledg");
    chk(3, 32'h0, 32'h0, "arst_hex");
    chk(4, 32'h0, 32'h0, "arst_irq");
    chk(0, io_a(5), 32'h0, "arst_keyedge");
    chk(0, io_a(6), 32'h0, "arst_keyie");
    chk(0, io_a(7), 32'h0, "arst_cycles");
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk(0, io_a(7), 32'd5, "cycles5");
    chk(0, io_a(7), 32'd6, "cycles6");
    chk(0, 32'h100, 32'hAA22_CC44, "ram_after_rst");

    idle(); idle();
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
